// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding memory read at a
// time and buffers returned words in an in-order queue. Optional macro: FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int          IQ_SIZE_WIDTH = 3,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        issue_ack,
  input  logic        target_valid,
  input  logic [31:0] target_pc,
  input  logic        rob_clear,
  input  logic [31:0] clear_pc,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stall,
`endif
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << IQ_SIZE_WIDTH;
  localparam logic [IQ_SIZE_WIDTH:0]   FULL_COUNT = (IQ_SIZE_WIDTH + 1)'(DEPTH);
  localparam logic [IQ_SIZE_WIDTH:0]   CNT_ONE    = (IQ_SIZE_WIDTH + 1)'(1);
  localparam logic [IQ_SIZE_WIDTH-1:0] PTR_ONE    = IQ_SIZE_WIDTH'(1);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_FETCH       = 2'd0,
    S_WAIT_MEM    = 2'd1,
    S_WAIT_TARGET = 2'd2
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_pc;
  logic [IQ_SIZE_WIDTH-1:0] r_head;
  logic [IQ_SIZE_WIDTH-1:0] r_tail;
  logic [IQ_SIZE_WIDTH:0] r_count;
  logic                   r_discard;
  logic                   r_mem_req_valid;
  logic [31:0]            r_mem_req_addr;
  logic [31:0]            r_iq_data [DEPTH];
  logic [31:0]            r_iq_addr [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_is_ctrl;
  logic w_pop;
  logic w_push;

  assign w_full    = (r_count == FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign w_is_ctrl = (mem_resp_data[6:0] == OP_JAL) ||
                     (mem_resp_data[6:0] == OP_JALR) ||
                     (mem_resp_data[6:0] == OP_BRANCH);
  assign w_pop     = issue_ack && !w_empty;
  assign w_push    = (r_state == S_WAIT_MEM) && mem_resp_valid && !r_discard;

  // Memory handshake: the request stays asserted with a stable address until the
  // single-cycle mem_resp_valid pulse; a request abandoned by a flush still owes
  // one response, which r_discard swallows before the next request may go out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_PC;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_discard       <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
    end else if (rdy) begin
      if (rob_clear) begin
        r_head          <= '0;
        r_tail          <= '0;
        r_count         <= '0;
        r_pc            <= clear_pc;
        r_state         <= S_FETCH;
        r_mem_req_valid <= 1'b0;
        if ((r_state == S_WAIT_MEM) && !mem_resp_valid) begin
          r_discard <= 1'b1;
        end else if (mem_resp_valid) begin
          r_discard <= 1'b0;
        end
      end else begin
        if (w_push) begin
          r_tail <= r_tail + PTR_ONE;
        end
        if (w_pop) begin
          r_head <= r_head + PTR_ONE;
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase

        unique case (r_state)
          S_FETCH: begin
            if (r_discard) begin
              if (mem_resp_valid) begin
                r_discard <= 1'b0;
              end
            end else if (!w_full) begin
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= r_pc;
              r_state         <= S_WAIT_MEM;
            end
          end
          S_WAIT_MEM: begin
            if (mem_resp_valid) begin
              r_mem_req_valid <= 1'b0;
              if (r_discard) begin
                r_discard <= 1'b0;
                r_state   <= S_FETCH;
              end else if (w_is_ctrl) begin
                // Sequential prefetch stops until decode resolves the target.
                r_state <= S_WAIT_TARGET;
              end else begin
                r_pc    <= r_pc + 32'd4;
                r_state <= S_FETCH;
              end
            end
          end
          S_WAIT_TARGET: begin
            if (target_valid) begin
              r_pc    <= target_pc;
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !rob_clear && w_push) begin
      r_iq_data[r_tail] <= mem_resp_data;
      r_iq_addr[r_tail] <= r_pc;
    end
  end

  assign mem_req_valid  = r_mem_req_valid;
  assign mem_req_addr   = r_mem_req_addr;
  assign instr_ready    = !w_empty;
  assign instr_out      = w_empty ? 32'h0 : r_iq_data[r_head];
  assign instr_addr_out = w_empty ? 32'h0 : r_iq_addr[r_head];
  assign dbg_state      = r_state;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_stall   <= '0;
    end else if (rdy) begin
      if (rob_clear) begin
        r_perf_flushed <= r_perf_flushed + 32'd1;
      end else if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (r_state == S_WAIT_TARGET) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level program-order model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic        issue_ack;
  logic        target_valid;
  logic [31:0] target_pc;
  logic        rob_clear;
  logic [31:0] clear_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.IQ_SIZE_WIDTH(3), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_addr_out(instr_addr_out),
    .issue_ack(issue_ack), .target_valid(target_valid), .target_pc(target_pc),
    .rob_clear(rob_clear), .clear_pc(clear_pc),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; issue_ack = 1'b0;
    target_valid = 1'b0; target_pc = '0; rob_clear = 1'b0; clear_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data);
    bit ok;
    wait_req(ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL serve_timeout actual=no_request expected=0x%08h", exp_addr);
      return;
    end
    check32("serve_addr", mem_req_addr, exp_addr);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case ((a >> 2) % 7)
      2:       op = 7'b1101111;
      4:       op = 7'b1100011;
      6:       op = 7'b1100111;
      default: op = 7'b0010011;
    endcase
    return {a[26:2], op};
  endfunction

  function automatic bit is_ctrl(input logic [31:0] w);
    return (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111) || (w[6:0] == 7'b1100011);
  endfunction

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        ack;
    logic        tv;
    logic [31:0] tpc;
    logic        clr;
    logic [31:0] cpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ready;
    logic [31:0] e_pc_out;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [18];

  // scoreboard: {instr, pc} expected at decode, in program order
  logic [63:0] exp_q [$];

  initial begin
    logic [31:0] model_pc;
    bit          awaiting;
    bit          slot_v;
    bit          slot_stale;
    logic [31:0] slot_addr;
    int          slot_lat;
    bit          ok;

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // reset state
    do_reset();
    check1("rst_req_valid", mem_req_valid, 1'b0);
    check32("rst_req_addr", mem_req_addr, 32'h0);
    check1("rst_ready", instr_ready, 1'b0);
    check32("rst_instr", instr_out, 32'h0);
    check32("rst_instr_addr", instr_addr_out, 32'h0);
    check32("rst_state", 32'(dbg_state), 32'h0);

    // directed table: addi, branch/target, flush with stale response, JAL, rdy gating
    //            rdy  resp data          ack  tv   tpc         clr  cpc        e_req e_addr     e_rdy e_pc       e_instr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h13,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h13};
    vecs[3]  = '{1'b1, 1'b1, 32'h63,       1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'h63};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'h63};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,    1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h4,   32'h63};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0,   32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h13,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h6f,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 32'h6f};
    vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0};
    vecs[16] = '{1'b0, 1'b1, 32'h13,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0};
    vecs[17] = '{1'b1, 1'b1, 32'h13,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 32'h13};

    for (int i = 0; i < 18; i++) begin
      rdy = vecs[i].rdy; mem_resp_valid = vecs[i].resp; mem_resp_data = vecs[i].data;
      issue_ack = vecs[i].ack; target_valid = vecs[i].tv; target_pc = vecs[i].tpc;
      rob_clear = vecs[i].clr; clear_pc = vecs[i].cpc;
      tick();
      check1($sformatf("vec%0d_req_valid", i), mem_req_valid, vecs[i].e_req);
      if (vecs[i].e_req) check32($sformatf("vec%0d_req_addr", i), mem_req_addr, vecs[i].e_addr);
      check1($sformatf("vec%0d_ready", i), instr_ready, vecs[i].e_ready);
      check32($sformatf("vec%0d_instr_addr", i), instr_addr_out, vecs[i].e_pc_out);
      check32($sformatf("vec%0d_instr", i), instr_out, vecs[i].e_instr);
    end
    idle_inputs();

    // fill the queue with issue_ack low, then one pop resumes fetch at 0x20
    do_reset();
    for (int i = 0; i < 8; i++) serve(32'(i * 4), 32'h13 | 32'(i << 7));
    tick(); tick(); tick();
    check1("full_no_req", mem_req_valid, 1'b0);
    check1("full_ready", instr_ready, 1'b1);
    check32("full_head", instr_addr_out, 32'h0);
    issue_ack = 1'b1;
    tick();
    issue_ack = 1'b0;
    check32("full_pop_head", instr_addr_out, 32'h4);
    check32("full_pop_instr", instr_out, 32'h93);
    serve(32'h20, 32'h13);

    // rob_clear on the same edge as a response and issue_ack, count = 3
    do_reset();
    serve(32'h0, 32'h13);
    serve(32'h4, 32'h13);
    serve(32'h8, 32'h13);
    wait_req(ok);
    check1("clr3_req_seen", ok, 1'b1);
    check32("clr3_req_addr", mem_req_addr, 32'hc);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h13; issue_ack = 1'b1;
    rob_clear = 1'b1; clear_pc = 32'h300;
    tick();
    idle_inputs();
    check1("clr3_ready", instr_ready, 1'b0);
    check32("clr3_instr", instr_out, 32'h0);
    check32("clr3_instr_addr", instr_addr_out, 32'h0);
    serve(32'h300, 32'h13);
    check1("clr3_new_ready", instr_ready, 1'b1);
    check32("clr3_new_addr", instr_addr_out, 32'h300);

    // reset while waiting on memory, then the late response arrives
    wait_req(ok);
    check32("rstmem_req_addr", mem_req_addr, 32'h304);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("rstmem_req_valid", mem_req_valid, 1'b0);
    check32("rstmem_req_addr0", mem_req_addr, 32'h0);
    check1("rstmem_ready", instr_ready, 1'b0);
    check32("rstmem_instr", instr_out, 32'h0);
    check32("rstmem_instr_addr", instr_addr_out, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
    check32("perf_flushed_rst", perf_flushed, 32'h0);
    check32("perf_fetched_rst", perf_fetched, 32'h0);
`endif
    mem_resp_valid = 1'b1; mem_resp_data = 32'h13;
    tick();
    mem_resp_valid = 1'b0;
    check1("rstmem_first_req", mem_req_valid, 1'b1);
    check32("rstmem_first_addr", mem_req_addr, 32'h0);
    check1("rstmem_late_dropped", instr_ready, 1'b0);
`ifdef FETCH_QUEUE_PERF_EN
    rob_clear = 1'b1; clear_pc = 32'h500;
    tick();
    rob_clear = 1'b0;
    check32("perf_flushed_one", perf_flushed, 32'h1);
    rdy = 1'b0; rob_clear = 1'b1;
    tick();
    idle_inputs();
    check32("perf_flushed_frozen", perf_flushed, 32'h1);
`endif

    // randomized traffic against the program-order model
    do_reset();
    exp_q.delete();
    model_pc = 32'h0; awaiting = 1'b0;
    slot_v = 1'b0; slot_stale = 1'b0; slot_addr = '0; slot_lat = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
      bit          pop_ok;
      exp_instr = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
      exp_pc    = (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0;
      check1("rnd_ready", instr_ready, exp_q.size() != 0);
      check32("rnd_instr", instr_out, exp_instr);
      check32("rnd_instr_addr", instr_addr_out, exp_pc);
      if (mem_req_valid) begin
        if (!slot_v) begin
          check32("rnd_req_addr", mem_req_addr, model_pc);
          check1("rnd_req_blocked", awaiting || (exp_q.size() >= 8), 1'b0);
          slot_v = 1'b1; slot_stale = 1'b0; slot_addr = model_pc;
          slot_lat = int'($urandom_range(0, 3));
        end else begin
          check1("rnd_req_during_discard", slot_stale, 1'b0);
          check32("rnd_req_hold", mem_req_addr, slot_addr);
        end
      end

      rdy            = ($urandom % 10) != 0;
      mem_resp_valid = slot_v && (slot_lat == 0) && rdy;
      mem_resp_data  = mem_resp_valid ? mem_word(slot_addr) : 32'h0;
      issue_ack      = ($urandom % 10) < 6;
      target_valid   = ($urandom % 10) < 3;
      target_pc      = 32'($urandom_range(0, 255)) << 2;
      rob_clear      = ($urandom % 50) == 0;
      clear_pc       = 32'($urandom_range(0, 1023)) << 2;
      if (slot_v && slot_lat > 0) slot_lat--;

      if (rdy) begin
        if (rob_clear) begin
          exp_q.delete();
          model_pc = clear_pc;
          awaiting = 1'b0;
          if (slot_v) begin
            if (mem_resp_valid) slot_v = 1'b0;
            else slot_stale = 1'b1;
          end
        end else begin
          pop_ok = issue_ack && (exp_q.size() != 0);
          if (target_valid && awaiting) begin
            model_pc = target_pc;
            awaiting = 1'b0;
          end
          if (mem_resp_valid) begin
            slot_v = 1'b0;
            if (!slot_stale) begin
              exp_q.push_back({mem_resp_data, slot_addr});
              if (is_ctrl(mem_resp_data)) awaiting = 1'b1;
              else model_pc = slot_addr + 32'd4;
            end
          end
          if (pop_ok) void'(exp_q.pop_front());
        end
      end
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
